// File: rtl/ama_riscv_spec_tracker.sv
// ama_riscv_spec_tracker
// Tracks predicted, still-unresolved conditional branches in program order.
// Each branch in EXE is matched against the oldest tracked entry. A mismatch
// between the prediction and the actual direction raises spec_wrong, and the
// checkpoint PC is presented for front-end recovery. The block also keeps
// saturating hit and miss statistics.
//
// Ports:
//   clk, rst         - clock; synchronous active-high reset
//   enter            - predicted branch in DEC wants to be tracked
//   pc_dec, bp_pred  - PC and predicted direction of that branch
//   enter_ready      - tracker not full; a push is accepted this cycle
//   exe_valid        - EXE holds a real instruction
//   pc_exe           - PC in EXE
//   branch_taken     - actual direction of the branch in EXE
//   flush            - external redirect; discards every entry
//   spec_active      - at least one entry is held
//   spec_resolve     - head entry resolves this cycle
//   spec_wrong       - head entry was mispredicted this cycle
//   pc_cp, cp_taken  - recovery checkpoint PC and the direction to take
//   occupancy        - number of entries held
//   hit_cnt/miss_cnt - saturating resolved-correct / resolved-wrong counts
module ama_riscv_spec_tracker #(
   parameter int SPEC_DEPTH = 2,
   parameter int ARCH_W     = 32,
   parameter int CNT_W      = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enter,
   input  logic [ARCH_W-1:0]               pc_dec,
   input  logic                            bp_pred,
   output logic                            enter_ready,
   input  logic                            exe_valid,
   input  logic [ARCH_W-1:0]               pc_exe,
   input  logic                            branch_taken,
   input  logic                            flush,
   output logic                            spec_active,
   output logic                            spec_resolve,
   output logic                            spec_wrong,
   output logic [ARCH_W-1:0]               pc_cp,
   output logic                            cp_taken,
   output logic [$clog2(SPEC_DEPTH+1)-1:0] occupancy,
   output logic [CNT_W-1:0]                hit_cnt,
   output logic [CNT_W-1:0]                miss_cnt
);

   localparam int PTR_W = (SPEC_DEPTH > 1) ? $clog2(SPEC_DEPTH) : 1;
   localparam int OCC_W = $clog2(SPEC_DEPTH+1);

   // The explicit wrap keeps SPEC_DEPTH == 1 correct, where the pointer has a
   // spare bit that must never count up.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(SPEC_DEPTH-1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   logic [ARCH_W-1:0]     pc_mem_r [SPEC_DEPTH];
   logic [SPEC_DEPTH-1:0] pred_mem_r;
   logic [PTR_W-1:0]      wptr_r;
   logic [PTR_W-1:0]      rptr_r;
   logic [OCC_W-1:0]      occupancy_r;
   logic [CNT_W-1:0]      hit_cnt_r;
   logic [CNT_W-1:0]      miss_cnt_r;

   logic                  full_s;
   logic                  active_s;
   logic [ARCH_W-1:0]     head_pc_s;
   logic                  head_pred_s;
   logic                  resolve_s;
   logic                  wrong_s;
   logic                  hit_s;
   logic                  push_s;
   logic                  clear_s;

   // Head decode and per-cycle control; everything depends on registered state and EXE/DEC inputs
   always_comb begin
      full_s      = (occupancy_r == OCC_W'(SPEC_DEPTH));
      active_s    = (occupancy_r != {OCC_W{1'b0}});
      head_pc_s   = pc_mem_r[rptr_r];
      head_pred_s = pred_mem_r[rptr_r];
      resolve_s   = exe_valid && active_s && (head_pc_s == pc_exe);
      wrong_s     = resolve_s && (head_pred_s != branch_taken);
      hit_s       = resolve_s && !wrong_s;
      // A DEC instruction that arrives during a misprediction is on the wrong path
      push_s      = enter && !full_s && !wrong_s && !flush;
      clear_s     = flush || wrong_s;
   end

   // Output drive; the head slot is masked when empty so stale entries never leak out
   always_comb begin
      enter_ready  = !full_s;
      spec_active  = active_s;
      spec_resolve = resolve_s;
      spec_wrong   = wrong_s;
      occupancy    = occupancy_r;
      hit_cnt      = hit_cnt_r;
      miss_cnt     = miss_cnt_r;
      if (active_s) begin
         pc_cp    = head_pc_s;
         cp_taken = resolve_s ? branch_taken : !head_pred_s;
      end else begin
         pc_cp    = {ARCH_W{1'b0}};
         cp_taken = 1'b0;
      end
   end

   // Entry storage; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_r[wptr_r]   <= pc_dec;
         pred_mem_r[wptr_r] <= bp_pred;
      end
   end

   // Pointers and occupancy; a clear beats any concurrent pop or push
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r      <= {PTR_W{1'b0}};
         rptr_r      <= {PTR_W{1'b0}};
         occupancy_r <= {OCC_W{1'b0}};
      end else if (clear_s) begin
         rptr_r      <= wptr_r;
         occupancy_r <= {OCC_W{1'b0}};
      end else begin
         if (push_s) begin
            wptr_r <= ptr_inc(wptr_r);
         end
         if (hit_s) begin
            rptr_r <= ptr_inc(rptr_r);
         end
         if (push_s && !hit_s) begin
            occupancy_r <= occupancy_r + OCC_W'(1);
         end else if (hit_s && !push_s) begin
            occupancy_r <= occupancy_r - OCC_W'(1);
         end
      end
   end

   // Saturating statistics; a resolve still counts when a flush arrives in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_r  <= {CNT_W{1'b0}};
         miss_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (hit_s && (hit_cnt_r != {CNT_W{1'b1}})) begin
            hit_cnt_r <= hit_cnt_r + CNT_W'(1);
         end
         if (wrong_s && (miss_cnt_r != {CNT_W{1'b1}})) begin
            miss_cnt_r <= miss_cnt_r + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ama_riscv_spec_tracker.sv
// tb_ama_riscv_spec_tracker
// Directed table plus randomized stimulus, checked against a queue-based
// reference model. A second instance with CNT_W=2 shares all inputs and
// exercises counter saturation.
module tb_ama_riscv_spec_tracker;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, enter, bp_pred, exe_valid, branch_taken, flush;
   logic [31:0] pc_dec, pc_exe;

   logic        enter_ready, spec_active, spec_resolve, spec_wrong, cp_taken;
   logic [31:0] pc_cp;
   logic [1:0]  occupancy;
   logic [15:0] hit_cnt, miss_cnt;

   logic        enter_ready2, spec_active2, spec_resolve2, spec_wrong2, cp_taken2;
   logic [31:0] pc_cp2;
   logic [1:0]  occupancy2;
   logic [1:0]  hit_cnt2, miss_cnt2;

   always #5 clk = ~clk;

   ama_riscv_spec_tracker #(.SPEC_DEPTH(DEPTH), .ARCH_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .enter(enter), .pc_dec(pc_dec), .bp_pred(bp_pred),
      .enter_ready(enter_ready), .exe_valid(exe_valid), .pc_exe(pc_exe),
      .branch_taken(branch_taken), .flush(flush), .spec_active(spec_active),
      .spec_resolve(spec_resolve), .spec_wrong(spec_wrong), .pc_cp(pc_cp),
      .cp_taken(cp_taken), .occupancy(occupancy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

   ama_riscv_spec_tracker #(.SPEC_DEPTH(DEPTH), .ARCH_W(32), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .enter(enter), .pc_dec(pc_dec), .bp_pred(bp_pred),
      .enter_ready(enter_ready2), .exe_valid(exe_valid), .pc_exe(pc_exe),
      .branch_taken(branch_taken), .flush(flush), .spec_active(spec_active2),
      .spec_resolve(spec_resolve2), .spec_wrong(spec_wrong2), .pc_cp(pc_cp2),
      .cp_taken(cp_taken2), .occupancy(occupancy2), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2));

   typedef struct {
      logic        e;
      logic [31:0] pcd;
      logic        pred;
      logic        ev;
      logic [31:0] pce;
      logic        bt;
      logic        fl;
      logic        rs;
      int          occ;
      logic        res;
      logic        wr;
      logic [31:0] pcc;
      logic        ct;
      int          hit;
      int          miss;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   ent_t q[$];
   int   m_hit, m_miss, m_hit2, m_miss2;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic e, input logic [31:0] pcd, input logic pred,
                               input logic ev, input logic [31:0] pce, input logic bt,
                               input logic fl, input int occ, input logic res,
                               input logic wr, input logic [31:0] pcc, input logic ct,
                               input int hit, input int miss);
      vec_t v;
      v.e = e; v.pcd = pcd; v.pred = pred; v.ev = ev; v.pce = pce; v.bt = bt;
      v.fl = fl; v.rs = 1'b0; v.occ = occ; v.res = res; v.wr = wr; v.pcc = pcc;
      v.ct = ct; v.hit = hit; v.miss = miss;
      return v;
   endfunction

   // Drive one cycle, check against the model (and the table when asked), advance the model.
   task automatic apply(input vec_t v, input bit use_tbl);
      bit          e_active, e_res, e_wr, e_ready;
      logic [31:0] e_pc;
      logic        e_ct;
      enter = v.e; pc_dec = v.pcd; bp_pred = v.pred; exe_valid = v.ev;
      pc_exe = v.pce; branch_taken = v.bt; flush = v.fl; rst = v.rs;
      #1;
      e_active = (q.size() != 0);
      e_ready  = (q.size() < DEPTH);
      e_res    = e_active && v.ev && (q[0].pc == v.pce);
      e_wr     = e_res && (q[0].pred != v.bt);
      e_pc     = e_active ? q[0].pc : 32'h0;
      e_ct     = e_active ? (e_res ? v.bt : !q[0].pred) : 1'b0;
      chk("enter_ready", enter_ready, e_ready);
      chk("spec_active", spec_active, e_active);
      chk("spec_resolve", spec_resolve, e_res);
      chk("spec_wrong", spec_wrong, e_wr);
      chk("pc_cp", pc_cp, e_pc);
      chk("cp_taken", cp_taken, e_ct);
      chk("occupancy", occupancy, q.size());
      chk("hit_cnt", hit_cnt, m_hit);
      chk("miss_cnt", miss_cnt, m_miss);
      chk("hit_cnt_w2", hit_cnt2, m_hit2);
      chk("miss_cnt_w2", miss_cnt2, m_miss2);
      if (use_tbl) begin
         chk("tbl_occupancy", occupancy, v.occ);
         chk("tbl_resolve", spec_resolve, v.res);
         chk("tbl_wrong", spec_wrong, v.wr);
         chk("tbl_pc_cp", pc_cp, v.pcc);
         chk("tbl_cp_taken", cp_taken, v.ct);
         chk("tbl_hit_cnt", hit_cnt, v.hit);
         chk("tbl_miss_cnt", miss_cnt, v.miss);
      end
      if (v.rs) begin
         q.delete();
         m_hit = 0; m_miss = 0; m_hit2 = 0; m_miss2 = 0;
      end else begin
         if (e_res && !e_wr) begin
            if (m_hit < 65535) m_hit++;
            if (m_hit2 < 3) m_hit2++;
         end
         if (e_wr) begin
            if (m_miss < 65535) m_miss++;
            if (m_miss2 < 3) m_miss2++;
         end
         if (v.fl || e_wr) begin
            q.delete();
         end else begin
            if (e_res) void'(q.pop_front());
            if (v.e && e_ready) q.push_back('{pc: v.pcd, pred: v.pred});
         end
      end
      @(negedge clk);
   endtask

   function automatic vec_t idle();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   vec_t tbl[23];
   vec_t v;

   initial begin
      // e  pcd    pr ev pce    bt fl | occ res wr pc_cp  ct hit miss
      tbl[0]  = mk(0, 0,      0, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 0, 0);
      tbl[1]  = mk(1, 32'h100, 1, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 0, 0);
      tbl[2]  = mk(0, 0,      0, 1, 32'h100, 1, 0,  1, 1, 0, 32'h100, 1, 0, 0);
      tbl[3]  = mk(0, 0,      0, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 1, 0);
      tbl[4]  = mk(1, 32'h100, 0, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 1, 0);
      tbl[5]  = mk(1, 32'h108, 1, 0, 0,      0, 0,  1, 0, 0, 32'h100, 1, 1, 0);
      tbl[6]  = mk(1, 32'h110, 0, 0, 0,      0, 0,  2, 0, 0, 32'h100, 1, 1, 0);
      tbl[7]  = mk(0, 0,      0, 1, 32'h100, 0, 0,  2, 1, 0, 32'h100, 0, 1, 0);
      tbl[8]  = mk(0, 0,      0, 0, 0,      0, 0,  1, 0, 0, 32'h108, 0, 2, 0);
      tbl[9]  = mk(0, 0,      0, 1, 32'h108, 1, 0,  1, 1, 0, 32'h108, 1, 2, 0);
      tbl[10] = mk(0, 0,      0, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 3, 0);
      tbl[11] = mk(1, 32'h200, 1, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 3, 0);
      tbl[12] = mk(1, 32'h210, 0, 0, 0,      0, 0,  1, 0, 0, 32'h200, 0, 3, 0);
      tbl[13] = mk(1, 32'h220, 1, 1, 32'h200, 0, 0,  2, 1, 1, 32'h200, 0, 3, 0);
      tbl[14] = mk(0, 0,      0, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 3, 1);
      tbl[15] = mk(1, 32'h300, 0, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 3, 1);
      tbl[16] = mk(1, 32'h304, 0, 0, 0,      0, 0,  1, 0, 0, 32'h300, 1, 3, 1);
      tbl[17] = mk(1, 32'h308, 1, 0, 0,      0, 1,  2, 0, 0, 32'h300, 1, 3, 1);
      tbl[18] = mk(0, 0,      0, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 3, 1);
      tbl[19] = mk(0, 0,      0, 1, 32'h0,  1, 0,  0, 0, 0, 32'h0,   0, 3, 1);
      tbl[20] = mk(1, 32'h0,  1, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 3, 1);
      tbl[21] = mk(0, 0,      0, 1, 32'h0,  1, 0,  1, 1, 0, 32'h0,   1, 3, 1);
      tbl[22] = mk(0, 0,      0, 0, 0,      0, 0,  0, 0, 0, 32'h0,   0, 4, 1);

      rst = 1'b1; enter = 1'b0; pc_dec = 32'h0; bp_pred = 1'b0; exe_valid = 1'b0;
      pc_exe = 32'h0; branch_taken = 1'b0; flush = 1'b0;
      m_hit = 0; m_miss = 0; m_hit2 = 0; m_miss2 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < 23; i++) apply(tbl[i], 1'b1);

      // Four hits on a 2-bit counter must hold at 3
      chk("hit_cnt_w2_saturated", hit_cnt2, 2'd3);

      // Steady state with one entry: hit at head plus push each cycle, pointers wrap
      apply(mk(1, 32'h400, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      for (int i = 1; i <= 8; i++) begin
         v = mk(1, 32'h400 + 32'(i) * 32'h4, 1'(i & 1), 1, 32'h400 + 32'(i - 1) * 32'h4,
                1'((i - 1) & 1) | (i == 1 ? 1'b1 : 1'b0), 0, 0, 0, 0, 0, 0, 0, 0);
         apply(v, 1'b0);
         chk("wrap_occupancy", occupancy, 2'd1);
         chk("wrap_head_pc", pc_cp, 32'h400 + 32'(i) * 32'h4);
      end

      // Reset in the middle of activity, with a push and a resolve pending
      apply(mk(1, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      v = mk(1, 32'h504, 1, 1, 32'h420, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.rs = 1'b1;
      apply(v, 1'b0);
      v = idle();
      v.ev = 1'b1; v.pce = 32'h500;
      apply(v, 1'b1);
      chk("post_rst_ready", enter_ready, 1'b1);

      // Randomized traffic over a small PC pool so resolves are frequent
      for (int i = 0; i < 400; i++) begin
         v = idle();
         v.e    = 1'($urandom_range(0, 1));
         v.pcd  = 32'h100 + 32'($urandom_range(0, 3)) * 32'h4;
         v.pred = 1'($urandom_range(0, 1));
         v.ev   = 1'($urandom_range(0, 1));
         v.pce  = 32'h100 + 32'($urandom_range(0, 3)) * 32'h4;
         if (q.size() != 0 && $urandom_range(0, 1) == 1) v.pce = q[0].pc;
         v.bt   = 1'($urandom_range(0, 1));
         v.fl   = ($urandom_range(0, 15) == 0);
         v.rs   = ($urandom_range(0, 63) == 0);
         apply(v, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ama_riscv_spec_tracker.md
# ama_riscv_spec_tracker

Parametrised speculation tracker for the front end. Records up to `SPEC_DEPTH` predicted, unresolved conditional branches in program order, matches them against the branch resolving in EXE, and flags mispredictions with the checkpoint PC needed for recovery. It sits beside the front-end stall FSM, which consumes `spec_wrong`/`pc_cp` and uses `enter_ready` to stall decode when the tracker is full. It also keeps saturating hit/miss statistics.

## Interface
Parameters:
- `SPEC_DEPTH`, 2: max in-flight predicted branches; power of two, ≥1.
- `ARCH_W`, 32: PC width.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enter` in 1: predicted branch in DEC, not stalled by backend; push request.
- `pc_dec` in ARCH_W: PC of the branch in DEC.
- `bp_pred` in 1: predicted direction (1 = taken).
- `enter_ready` out 1: push accepted this cycle.
- `exe_valid` in 1: instruction in EXE is real (not a bubble, no hazard stall).
- `pc_exe` in ARCH_W: PC in EXE.
- `branch_taken` in 1: actual direction of the branch in EXE.
- `flush` in 1: external redirect (jalr, trap); discards all entries.
- `spec_active` out 1: occupancy ≠ 0.
- `spec_resolve` out 1: head entry resolves this cycle.
- `spec_wrong` out 1: head entry mispredicted this cycle.
- `pc_cp` out ARCH_W: PC of head entry (recovery checkpoint).
- `cp_taken` out 1: actual direction to recover with (equals `branch_taken` when `spec_wrong`).
- `occupancy` out $clog2(SPEC_DEPTH+1): entries held.
- `hit_cnt`, `miss_cnt` out CNT_W: resolved-correct / resolved-wrong counts.

## Operation
- Storage: circular buffer of `{pc, pred}`, write pointer, read pointer, and separate occupancy counter. Pointer width is max(1, $clog2(SPEC_DEPTH)); pointers wrap modulo `SPEC_DEPTH`.
- `enter_ready = !full` (full means occupancy == SPEC_DEPTH). It depends only on registered state. There is no same-cycle bypass through a popping head.
- Push: `enter && enter_ready && !spec_wrong && !flush` writes at wptr, increments wptr and occupancy.
- Resolve: `spec_resolve = exe_valid && spec_active && (head.pc == pc_exe)`.
- `spec_wrong = spec_resolve && (head.pred != branch_taken)`. A hit is `spec_resolve && !spec_wrong`.
- Hit: pop head (rptr+1, occupancy-1). A concurrent push is allowed, giving occupancy net 0.
- Wrong: clear all entries (rptr = wptr, occupancy = 0). The concurrent `enter` is dropped because the DEC instruction is wrong-path.
- `flush`: same clear as wrong. It has priority over push and pop. A resolve in the same cycle still drives `spec_resolve`/`spec_wrong` outputs and updates the counters.
- Priority per cycle: flush/wrong clear > pop/push.
- `pc_cp` = head.pc, `cp_taken` = `branch_taken` when resolving, else `!head.pred`. When empty, `pc_cp` = 0 and `cp_taken` = 0.
- Counters: `hit_cnt` increments on a hit and `miss_cnt` on `spec_wrong`. Both saturate at all-ones and never wrap.
- Entry contents are not reset, only pointers and occupancy. Outputs must never expose stale entries.

## Timing
- Reset values: occupancy 0, pointers 0, `enter_ready` 1, `spec_active` 0, `spec_resolve` 0, `spec_wrong` 0, `pc_cp` 0, `cp_taken` 0, `hit_cnt` 0, `miss_cnt` 0.
- `spec_resolve`, `spec_wrong`, `cp_taken` are combinational from registered head and EXE inputs, in the same cycle as resolution. The FE redirect uses them in that cycle.
- A pushed entry is visible as head (`pc_cp`) from the next cycle. The earliest resolve is 1 cycle after push.
- `occupancy`, `enter_ready`, `spec_active` update 1 cycle after push/pop/clear.
- `rst` asserted mid-operation: all entries discarded next edge, counters cleared. No output may assert during the reset cycle's aftermath until new pushes occur.
- Full: `enter` while full is ignored (FE holds DEC). A hit in that cycle frees a slot visible next cycle.
- Empty: `exe_valid` with any `pc_exe` gives no resolve. A PC of 0 is a legal entry.

## Test plan
- Reset, then push `pc_dec=0x100, pred=1`; next cycle `pc_exe=0x100, branch_taken=1, exe_valid=1` -> `spec_resolve=1`, `spec_wrong=0`, `hit_cnt=1`, occupancy 1→0.
- DEPTH=2: push 0x100 (pred 0), 0x108 (pred 1) -> `enter_ready=0`. A third `enter` is ignored. Resolve 0x100 hit -> occupancy 1 and `pc_cp=0x108` next cycle.
- Push 0x200 (pred 1), 0x210; resolve 0x200 with `branch_taken=0` plus concurrent `enter` 0x220 -> `spec_wrong=1`, `pc_cp=0x200`, `cp_taken=0`, `miss_cnt=1`, occupancy 0 next cycle (0x220 dropped).
- Hit at head with simultaneous push on a DEPTH=2 tracker holding 1 entry -> occupancy stays 1, pointers wrap correctly over 8 consecutive such cycles, head PCs match push order.
- `flush` with 2 entries plus concurrent `enter` -> occupancy 0, `spec_active=0`, no counter change.
- CNT_W=2: 5 hits -> `hit_cnt` holds 3. Assert `rst` mid-stream -> all outputs at reset values next cycle.
